// File: rtl/lector_pixeles_mem_param.sv
// Memory read controller + word FIFO that unpacks fetched words into pixels for the window.
// Define PIXEL_MSB_PRIMERO_EN to hand out pixels MSB-first instead of LSB-first.
module lector_pixeles_mem_param #(
    parameter int BITS_MEMORY_DATA   = 32,
    parameter int BITS_PIXEL         = 8,
    parameter int BITS_DIRECCION_MEM = 14,
    parameter int BITS_PUNTERO_FIFO  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          iniciar,
    input  logic [BITS_DIRECCION_MEM-1:0] direccion_mem_inicio_img,
    input  logic [BITS_DIRECCION_MEM-1:0] lecturas_totales_mem,
    input  logic                          lectura_mem_completada,
    input  logic [BITS_MEMORY_DATA-1:0]   memory_data,
    input  logic                          read_pixel,
    output logic                          read_mem,
    output logic [BITS_DIRECCION_MEM-1:0] address_mem,
    output logic [BITS_PIXEL-1:0]         pixel,
    output logic                          data_available,
    output logic                          ocupado,
    output logic                          terminado
);
    localparam int PIX_POR_PALABRA = BITS_MEMORY_DATA / BITS_PIXEL;
    localparam int PROFUNDIDAD     = 1 << BITS_PUNTERO_FIFO;
    localparam int BITS_IDX        = (PIX_POR_PALABRA > 1) ? $clog2(PIX_POR_PALABRA) : 1;

    localparam logic [BITS_IDX-1:0]           IDX_ULTIMO   = BITS_IDX'(PIX_POR_PALABRA - 1);
    localparam logic [BITS_IDX-1:0]           IDX_UNO      = BITS_IDX'(1);
    localparam logic [BITS_PUNTERO_FIFO:0]    CUENTA_LLENA = (BITS_PUNTERO_FIFO + 1)'(PROFUNDIDAD);
    localparam logic [BITS_PUNTERO_FIFO:0]    CUENTA_UNO   = (BITS_PUNTERO_FIFO + 1)'(1);
    localparam logic [BITS_PUNTERO_FIFO-1:0]  PTR_UNO      = BITS_PUNTERO_FIFO'(1);
    localparam logic [BITS_DIRECCION_MEM-1:0] DIR_UNO      = BITS_DIRECCION_MEM'(1);

    typedef enum logic [1:0] {REPOSO, LEER, DRENAR, FIN} estado_t;

    estado_t                         estado_q, estado_d;
    logic [BITS_DIRECCION_MEM-1:0]   dir_q, dir_d;
    logic [BITS_DIRECCION_MEM-1:0]   restantes_q, restantes_d;
    logic                            read_mem_q, read_mem_d;
    logic [BITS_MEMORY_DATA-1:0]     fifo_q [PROFUNDIDAD];
    logic [BITS_MEMORY_DATA-1:0]     fifo_d [PROFUNDIDAD];
    logic [BITS_PUNTERO_FIFO-1:0]    wr_ptr_q, wr_ptr_d;
    logic [BITS_PUNTERO_FIFO-1:0]    rd_ptr_q, rd_ptr_d;
    logic [BITS_PUNTERO_FIFO:0]      cuenta_q, cuenta_d;
    logic [BITS_IDX-1:0]             idx_q, idx_d;

    logic                                     hay_dato, push, avanza, pop;
    logic [PIX_POR_PALABRA-1:0][BITS_PIXEL-1:0] cabeza;
    logic [BITS_IDX-1:0]                      sel;

    assign hay_dato = (cuenta_q != '0);
    // A strobe only counts while a read is actually outstanding.
    assign push     = read_mem_q && lectura_mem_completada;
    assign avanza   = read_pixel && hay_dato;
    assign pop      = avanza && (idx_q == IDX_ULTIMO);
    assign cabeza   = fifo_q[rd_ptr_q];

`ifdef PIXEL_MSB_PRIMERO_EN
    assign sel = IDX_ULTIMO - idx_q;
`else
    assign sel = idx_q;
`endif

    always_comb begin
        estado_d    = estado_q;
        dir_d       = dir_q;
        restantes_d = restantes_q;
        read_mem_d  = read_mem_q;
        case (estado_q)
            REPOSO, FIN: begin
                if (iniciar) begin
                    dir_d       = direccion_mem_inicio_img;
                    restantes_d = lecturas_totales_mem;
                    estado_d    = (lecturas_totales_mem == '0) ? FIN : LEER;
                end
            end
            LEER: begin
                if (push) begin
                    read_mem_d  = 1'b0;
                    dir_d       = dir_q + DIR_UNO;
                    restantes_d = restantes_q - DIR_UNO;
                    if (restantes_q == DIR_UNO) estado_d = DRENAR;
                end else if (!read_mem_q && (cuenta_q < CUENTA_LLENA)) begin
                    read_mem_d = 1'b1;
                end
            end
            DRENAR: begin
                if (!hay_dato && (idx_q == '0)) estado_d = FIN;
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cuenta_d = cuenta_q;
        idx_d    = idx_q;
        if (push) begin
            fifo_d[wr_ptr_q] = memory_data;
            wr_ptr_d         = wr_ptr_q + PTR_UNO;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_UNO;
        case ({push, pop})
            2'b10:   cuenta_d = cuenta_q + CUENTA_UNO;
            2'b01:   cuenta_d = cuenta_q - CUENTA_UNO;
            default: cuenta_d = cuenta_q;
        endcase
        if (avanza) idx_d = pop ? '0 : idx_q + IDX_UNO;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= REPOSO;
            dir_q       <= '0;
            restantes_q <= '0;
            read_mem_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cuenta_q    <= '0;
            idx_q       <= '0;
            for (int i = 0; i < PROFUNDIDAD; i++) fifo_q[i] <= '0;
        end else begin
            estado_q    <= estado_d;
            dir_q       <= dir_d;
            restantes_q <= restantes_d;
            read_mem_q  <= read_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cuenta_q    <= cuenta_d;
            idx_q       <= idx_d;
            fifo_q      <= fifo_d;
        end
    end

    assign read_mem       = read_mem_q;
    assign address_mem    = dir_q;
    assign data_available = hay_dato;
    assign pixel          = hay_dato ? cabeza[sel] : '0;
    assign ocupado        = (estado_q == LEER) || (estado_q == DRENAR);
    assign terminado      = (estado_q == FIN);
endmodule

// File: tb/tb_lector_pixeles_mem_param.sv
// Directed + randomized bench for lector_pixeles_mem_param against a word-list/pixel-queue model.
module tb_lector_pixeles_mem_param;
    localparam int BMD = 32, BP = 8, BD = 14, BF = 2, PPW = BMD / BP;

    logic          clk = 1'b0, rst_n = 1'b0, iniciar = 1'b0, read_pixel = 1'b0;
    logic [BD-1:0] base_in = '0, cnt_in = '0;
    logic          auto_cmp = 1'b0, man_cmp = 1'b0;
    logic [BMD-1:0] auto_data = '0, man_data = '0;
    logic          lectura_mem_completada;
    logic [BMD-1:0] memory_data;
    logic          read_mem, data_available, ocupado, terminado;
    logic [BD-1:0] address_mem;
    logic [BP-1:0] pixel;

    assign lectura_mem_completada = auto_cmp | man_cmp;
    assign memory_data            = auto_cmp ? auto_data : man_data;

    lector_pixeles_mem_param #(
        .BITS_MEMORY_DATA(BMD), .BITS_PIXEL(BP),
        .BITS_DIRECCION_MEM(BD), .BITS_PUNTERO_FIFO(BF)
    ) dut (
        .clk(clk), .reset(rst_n), .iniciar(iniciar),
        .direccion_mem_inicio_img(base_in), .lecturas_totales_mem(cnt_in),
        .lectura_mem_completada(lectura_mem_completada), .memory_data(memory_data),
        .read_pixel(read_pixel), .read_mem(read_mem), .address_mem(address_mem),
        .pixel(pixel), .data_available(data_available), .ocupado(ocupado),
        .terminado(terminado)
    );

    always #5 clk = ~clk;

    logic [BMD-1:0] mem [1 << BD];
    logic [BP-1:0]  exp_q [$];
    logic [BD-1:0]  req_log [$];
    int             req_start = 0;
    logic [BD-1:0]  exp_base = '0;
    int             exp_cnt = 0;
    int             checks = 0, errors = 0;
    int             lat = 0, espera = 0, hold_viol = 0;
    bit             resp_en = 1'b1;
    logic           prev_rm = 1'b0, prev_cmp = 1'b0;
    logic [BD-1:0]  prev_a = '0;

    // Off-chip memory: answers each request after lat idle cycles.
    always @(negedge clk) begin
        auto_cmp = 1'b0;
        if (!rst_n || !resp_en || !read_mem) espera = 0;
        else if (espera >= lat) begin
            auto_cmp  = 1'b1;
            auto_data = mem[address_mem];
            espera    = 0;
        end else espera++;
    end

    // Logs completed reads and flags any request that changes before it is answered.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_rm <= 1'b0;
        else begin
            if (prev_rm && !prev_cmp && (read_mem !== 1'b1 || address_mem !== prev_a))
                hold_viol <= hold_viol + 1;
            if (read_mem && lectura_mem_completada) req_log.push_back(address_mem);
            prev_rm  <= read_mem;
            prev_cmp <= lectura_mem_completada;
            prev_a   <= address_mem;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [BP-1:0] pix_of(logic [BMD-1:0] w, int k);
        logic [BMD-1:0] t;
`ifdef PIXEL_MSB_PRIMERO_EN
        t = w >> ((PPW - 1 - k) * BP);
`else
        t = w >> (k * BP);
`endif
        return t[BP-1:0];
    endfunction

    task automatic start(logic [BD-1:0] b, logic [BD-1:0] c);
        logic [BD-1:0] a;
        exp_q.delete();
        for (int i = 0; i < int'(c); i++) begin
            a = b + BD'(i);
            for (int k = 0; k < PPW; k++) exp_q.push_back(pix_of(mem[a], k));
        end
        req_start = req_log.size();
        exp_base  = b;
        exp_cnt   = int'(c);
        base_in   = b;
        cnt_in    = c;
        iniciar   = 1'b1;
        @(negedge clk);
        iniciar   = 1'b0;
        base_in   = $urandom();
        cnt_in    = $urandom();
    endtask

    task automatic wait_rm(int budget);
        int n = 0;
        while (read_mem !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("espera_read_mem", read_mem, 1);
    endtask

    task automatic fin_checks();
        logic [BD-1:0] a;
        chk("terminado", terminado, 1);
        chk("ocupado_fin", ocupado, 0);
        chk("avail_fin", data_available, 0);
        chk("pix_restantes", exp_q.size(), 0);
        chk("n_lecturas", req_log.size() - req_start, exp_cnt);
        for (int i = 0; i < exp_cnt && req_start + i < req_log.size(); i++) begin
            a = exp_base + BD'(i);
            chk("dir", req_log[req_start + i], a);
        end
        chk("hold", hold_viol, 0);
    endtask

    task automatic drain(int prob, int budget);
        int n = 0;
        while (terminado !== 1'b1 && n < budget) begin
            if (data_available === 1'b1 && $urandom_range(99) < prob) begin
                if (exp_q.size() == 0) chk("pix_extra", exp_q.size(), 1);
                else chk("pixel", pixel, exp_q.pop_front());
                read_pixel = 1'b1;
            end else begin
                read_pixel = (data_available === 1'b1) ? 1'b0 : 1'($urandom_range(1));
            end
            @(negedge clk);
            n++;
        end
        read_pixel = 1'b0;
        fin_checks();
    endtask

    initial begin
        logic [BD-1:0] b, a;
        for (int i = 0; i < (1 << BD); i++) mem[i] = $urandom();
        mem[16] = 32'h4433_2211;

        // Reset values
        #1;
        chk("rst_read_mem", read_mem, 0);
        chk("rst_address", address_mem, 0);
        chk("rst_pixel", pixel, 0);
        chk("rst_avail", data_available, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_terminado", terminado, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unpacking of one word, manual memory answer
        resp_en = 1'b0;
        start(14'h0010, 14'd1);
        wait_rm(10);
        chk("unp_dir", address_mem, 14'h0010);
        chk("unp_ocupado", ocupado, 1);
        man_data = mem[address_mem];
        man_cmp = 1'b1;
        read_pixel = 1'b1;
        @(negedge clk);
        man_cmp = 1'b0;
        for (int k = 0; k < PPW; k++) begin
            chk("unp_avail", data_available, 1);
`ifdef PIXEL_MSB_PRIMERO_EN
            chk("unp_pixel", pixel, 8'h11 * (4 - k));
`else
            chk("unp_pixel", pixel, 8'h11 * (k + 1));
`endif
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        resp_en = 1'b1;
        drain(100, 10);

        // Zero count
        start($urandom(), 14'd0);
        chk("zero_terminado", terminado, 1);
        chk("zero_read_mem", read_mem, 0);
        repeat (3) @(negedge clk);
        chk("zero_read_mem2", read_mem, 0);
        fin_checks();

        // Back-pressure: FIFO fills to 4 words, then one pop word frees one read
        lat = 2;
        b = $urandom();
        start(b, 14'd8);
        read_pixel = 1'b0;
        repeat (40) @(negedge clk);
        chk("bp_lecturas", req_log.size() - req_start, 4);
        chk("bp_read_mem", read_mem, 0);
        chk("bp_avail", data_available, 1);
        for (int k = 0; k < PPW; k++) begin
            chk("bp_pixel", pixel, exp_q.pop_front());
            read_pixel = 1'b1;
            @(negedge clk);
        end
        read_pixel = 1'b0;
        repeat (12) @(negedge clk);
        chk("bp_lecturas2", req_log.size() - req_start, 5);
        a = b + 14'd4;
        if (req_log.size() > req_start + 4) chk("bp_dir5", req_log[req_start + 4], a);
        drain(70, 500);

        // Address wrap
        lat = 1;
        start(14'h3FFE, 14'd3);
        drain(100, 200);
        if (req_log.size() > req_start + 2) chk("wrap_dir_cero", req_log[req_start + 2], 14'h0000);

        // Randomized transfers
        for (int t = 0; t < 6; t++) begin
            lat = $urandom_range(0, 3);
            start($urandom(), 14'($urandom_range(1, 9)));
            drain($urandom_range(30, 100), 1000);
        end

        // Reset while a read is outstanding
        resp_en = 1'b0;
        start($urandom(), 14'd5);
        wait_rm(10);
        rst_n = 1'b0;
        #1;
        chk("rstm_read_mem", read_mem, 0);
        chk("rstm_avail", data_available, 0);
        chk("rstm_ocupado", ocupado, 0);
        chk("rstm_address", address_mem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        man_data = $urandom();
        man_cmp = 1'b1;
        @(negedge clk);
        man_cmp = 1'b0;
        chk("rstm_tardia_avail", data_available, 0);
        @(negedge clk);
        chk("rstm_tardia_avail2", data_available, 0);
        chk("rstm_tardia_read_mem", read_mem, 0);
        resp_en = 1'b1;
        lat = 0;
        start($urandom(), 14'd3);
        drain(100, 200);

        // Push and pop in the same cycle
        resp_en = 1'b0;
        start($urandom(), 14'd2);
        wait_rm(10);
        man_data = mem[address_mem];
        man_cmp = 1'b1;
        @(negedge clk);
        man_cmp = 1'b0;
        for (int k = 0; k < PPW - 1; k++) begin
            chk("pp_pixel", pixel, exp_q.pop_front());
            read_pixel = 1'b1;
            @(negedge clk);
        end
        chk("pp_read_mem", read_mem, 1);
        chk("pp_pixel_ult", pixel, exp_q.pop_front());
        read_pixel = 1'b1;
        man_data = mem[address_mem];
        man_cmp = 1'b1;
        @(negedge clk);
        man_cmp = 1'b0;
        read_pixel = 1'b0;
        chk("pp_avail", data_available, 1);
        chk("pp_pixel_b0", pixel, exp_q[0]);
        resp_en = 1'b1;
        drain(100, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lector_pixeles_mem_param.md
Name: lector_pixeles_mem_param

Overview:
Parametrised successor to the external-memory read controller and pixel buffer pair, merged into one block. It fetches a programmed number of consecutive words from off-chip memory starting at a base address. Fetched words are held in an internal word FIFO, and pixels of configurable width are handed out one at a time to the pixel window. It sits between the off-chip memory port 1 and ventana_pixeles, and is started by the program counter's "programa leido" pulse.

Parameters:
BITS_MEMORY_DATA, 32, memory word width; must be an integer multiple of BITS_PIXEL
BITS_PIXEL, 8, pixel width
BITS_DIRECCION_MEM, 14, memory address and read-count width
BITS_PUNTERO_FIFO, 2, log2 of FIFO depth in words (depth = 4 by default)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
iniciar  in  1  one-cycle start pulse
direccion_mem_inicio_img  in  BITS_DIRECCION_MEM  base address, latched on iniciar
lecturas_totales_mem  in  BITS_DIRECCION_MEM  number of words to read, latched on iniciar
lectura_mem_completada  in  1  one-cycle read-done strobe; memory_data valid in the same cycle
memory_data  in  BITS_MEMORY_DATA  read data
read_pixel  in  1  consumer pops the current pixel
read_mem  out  1  memory read request
address_mem  out  BITS_DIRECCION_MEM  read address
pixel  out  BITS_PIXEL  current pixel
data_available  out  1  pixel output is valid
ocupado  out  1  high in every state except REPOSO and FIN
terminado  out  1  all words read and all pixels consumed

Behaviour:
- Reset values (asserted asynchronously on reset low): read_mem=0, address_mem=0, pixel=0, data_available=0, ocupado=0, terminado=0. FIFO is emptied, the pixel index is cleared and the FSM goes to REPOSO.
- Derived constant: PIX_POR_PALABRA = BITS_MEMORY_DATA / BITS_PIXEL.
- FSM states:
  - REPOSO: on iniciar, latch the base address and count. Go to FIN if the count is 0, otherwise go to LEER.
  - LEER: issue memory reads as described below. When the last word is written into the FIFO, go to DRENAR.
  - DRENAR: no further reads. When the FIFO is empty and the pixel index is 0, go to FIN.
  - FIN: terminado=1, held. On iniciar, behave exactly as REPOSO does.
- iniciar is ignored in LEER and DRENAR.
- Memory handshake:
  - At most one read outstanding.
  - read_mem rises only when the FIFO word count is below the depth.
  - Once raised, read_mem and address_mem stay stable until the cycle in which lectura_mem_completada is seen.
  - In that cycle: the word is written into the FIFO, and read_mem drops at the next edge.
  - Also on that edge: address increments, and the remaining count decrements.
  - The next request may assert one cycle later.
  - The address wraps modulo 2^BITS_DIRECCION_MEM.
  - lectura_mem_completada with read_mem low is ignored.
- Space check: because the FIFO count is checked before each request and only one read is outstanding, a write to a full FIFO cannot occur.
- Pixel output:
  - data_available = FIFO not empty.
  - pixel = slice [idx*BITS_PIXEL +: BITS_PIXEL] of the FIFO head word, combinational from the head word and the index (pixel is 0 when the FIFO is empty).
  - Default order is LSB-first.
- Pixel pop:
  - read_pixel with data_available=1 advances idx.
  - When idx = PIX_POR_PALABRA-1, the head word is popped and idx returns to 0.
  - read_pixel with data_available=0 is ignored.
- A FIFO push and pop in the same cycle are both honoured; the word count is unchanged.
- Latency: the first pixel is valid in the cycle after the completada strobe of the first word.
- Reset mid-transfer abandons the outstanding read; any late completada strobe arriving in REPOSO is ignored.

Optional Feature:
Macro PIXEL_MSB_PRIMERO_EN.
- Defined: pixels are extracted MSB-first, i.e. slice index (PIX_POR_PALABRA-1-idx).
- Undefined: LSB-first as above.
- FIFO, handshake and FSM behaviour are identical in both builds.

Test Plan:
- Unpacking: base 0x0010, count 1, memory returns 0x44332211, read_pixel held high.
  - Default build: read_mem asserted with address 0x0010; pixels 0x11, 0x22, 0x33, 0x44 on consecutive cycles; then terminado=1 and ocupado=0.
  - With PIXEL_MSB_PRIMERO_EN: pixels 0x44, 0x33, 0x22, 0x11.
- Zero count: iniciar with count 0 -> read_mem never asserts; terminado=1 one cycle after iniciar.
- Back-pressure: count 8, read_pixel held low, memory completes every request after 2 cycles -> exactly 4 reads (addresses base..base+3). read_mem then stays low and data_available=1. Popping 4 pixels frees one word and exactly one new read is issued, at base+4.
- Address wrap: base 0x3FFE, count 3 -> request addresses 0x3FFE, 0x3FFF, 0x0000; 12 pixels delivered in order; terminado=1.
- Reset mid-operation: assert reset while read_mem=1 -> read_mem, data_available and ocupado drop immediately, before the next clock edge. Release reset, then pulse completada -> no FIFO write and data_available stays 0. A new iniciar starts cleanly from the newly latched base.
- Simultaneous push and pop: FIFO holding 1 word, last pixel popped in the same cycle as completada -> word count stays 1; new word's first pixel is presented in the next cycle.
